// File: rtl/hdmi_tmds_encode_multi.sv
// Multi-lane HDMI channel encoder: CTL, TMDS video, TERC4 data island and guard-band symbols.
// Four-stage pipeline; each lane's running disparity is read and written only in the last stage.
module hdmi_tmds_encode_multi #(
    parameter int NCH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [1:0]        i_mode,
    input  logic              i_gb_di,
    input  logic [8*NCH-1:0]  i_vd,
    input  logic [2*NCH-1:0]  i_cd,
    input  logic [4*NCH-1:0]  i_aux,
    output logic              o_en,
    output logic [10*NCH-1:0] o_tmds_bits
);
    typedef enum logic [1:0] {
        MODE_CTL   = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_e;

    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic use_xnor(input logic [7:0] d);
        logic [3:0] n;
        n = ones8(d);
        return (n > 4'd4) || (n == 4'd4 && !d[0]);
    endfunction

    function automatic logic [8:0] qm_calc(input logic [7:0] d, input logic xn);
        logic [8:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xn;
        return q;
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] n);
        case (n)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000111;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    logic                s1_en, s2_en, s3_en;
    mode_e               s1_mode, s2_mode, s3_mode;
    logic                s1_gb, s2_gb, s3_gb;
    logic [2*NCH-1:0]    s1_cd, s2_cd, s3_cd;
    logic [4*NCH-1:0]    s1_aux, s2_aux, s3_aux;
    logic [7:0]          s1_vd   [NCH];
    logic [NCH-1:0]      s1_xnor;
    logic [8:0]          s2_qm   [NCH];
    logic [8:0]          s3_qm   [NCH];
    logic signed [5:0]   s3_diff [NCH];
    logic [NCH-1:0]      s3_bal;
    logic signed [5:0]   cnt     [NCH];
    logic signed [5:0]   cnt_nxt [NCH];
    logic [9:0]          sym     [NCH];

    // NOTE: sequential state uses <= so each stage samples the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_en <= 1'b0;
            s2_en <= 1'b0;
            s3_en <= 1'b0;
        end else begin
            s1_en <= i_en;
            s2_en <= s1_en;
            s3_en <= s2_en;
        end
    end

    // NOTE: payload registers carry no reset; the stage valids alone decide whether they are used.
    always_ff @(posedge clk) begin
        s1_mode <= mode_e'(i_mode);
        s1_gb   <= i_gb_di;
        s1_cd   <= i_cd;
        s1_aux  <= i_aux;
        s2_mode <= s1_mode;
        s2_gb   <= s1_gb;
        s2_cd   <= s1_cd;
        s2_aux  <= s1_aux;
        s3_mode <= s2_mode;
        s3_gb   <= s2_gb;
        s3_cd   <= s2_cd;
        s3_aux  <= s2_aux;
        for (int k = 0; k < NCH; k++) begin
            s1_vd[k]   <= i_vd[8*k +: 8];
            s1_xnor[k] <= use_xnor(i_vd[8*k +: 8]);
            s2_qm[k]   <= qm_calc(s1_vd[k], s1_xnor[k]);
            s3_qm[k]   <= s2_qm[k];
            s3_diff[k] <= $signed({1'b0, ones8(s2_qm[k][7:0]), 1'b0}) - 6'sd8;
            s3_bal[k]  <= (ones8(s2_qm[k][7:0]) == 4'd4);
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sym[k]     = '0;
            cnt_nxt[k] = '0;
            case (s3_mode)
                MODE_VIDEO: begin
                    if (s3_bal[k] || cnt[k] == 6'sd0) begin
                        sym[k]     = {~s3_qm[k][8], s3_qm[k][8],
                                      s3_qm[k][8] ? s3_qm[k][7:0] : ~s3_qm[k][7:0]};
                        cnt_nxt[k] = s3_qm[k][8] ? cnt[k] + s3_diff[k] : cnt[k] - s3_diff[k];
                    end else if (cnt[k][5] == s3_diff[k][5]) begin
                        // both are nonzero here, so matching signs means the bias would grow
                        sym[k]     = {1'b1, s3_qm[k][8], ~s3_qm[k][7:0]};
                        cnt_nxt[k] = cnt[k] + (s3_qm[k][8] ? 6'sd2 : 6'sd0) - s3_diff[k];
                    end else begin
                        sym[k]     = {1'b0, s3_qm[k][8], s3_qm[k][7:0]};
                        cnt_nxt[k] = cnt[k] - (s3_qm[k][8] ? 6'sd0 : 6'sd2) + s3_diff[k];
                    end
                end
                MODE_CTL:   sym[k] = ctl_sym(s3_cd[2*k +: 2]);
                MODE_TERC4: sym[k] = terc4(s3_aux[4*k +: 4]);
                MODE_GUARD: begin
                    if (!s3_gb) sym[k] = (k % 3 == 1) ? GB_B : GB_A;
                    else        sym[k] = (k % 3 == 0) ? terc4(s3_aux[4*k +: 4]) : GB_B;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_en        <= 1'b0;
            o_tmds_bits <= '0;
            for (int k = 0; k < NCH; k++) cnt[k] <= '0;
        end else begin
            o_en <= s3_en;
            if (s3_en) begin
                for (int k = 0; k < NCH; k++) begin
                    o_tmds_bits[10*k +: 10] <= sym[k];
                    cnt[k]                  <= cnt_nxt[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_hdmi_tmds_encode_multi.sv
// Directed and model-checked bench for hdmi_tmds_encode_multi; a 3-lane and a 5-lane
// instance share one stimulus bus, the 3-lane one seeing the low lanes.
module tb_hdmi_tmds_encode_multi;
    typedef struct packed {
        logic        en3;
        logic [29:0] b3;
        logic        en5;
        logic [49:0] b5;
    } obs_t;

    localparam logic [1:0] M_CTL = 2'b00, M_VID = 2'b01, M_TERC = 2'b10, M_GB = 2'b11;
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;
    localparam logic [9:0] Z1   = 10'b0100000000;
    localparam logic [9:0] Z2   = 10'b1111111111;
    localparam logic [9:0] F1   = 10'b1000000000;
    localparam logic [9:0] F2   = 10'b0011111111;
    localparam logic [9:0] CTL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                           10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_en = 1'b0;
    logic [1:0]  i_mode = '0;
    logic        i_gb_di = 1'b0;
    logic [39:0] i_vd = '0;
    logic [9:0]  i_cd = '0;
    logic [19:0] i_aux = '0;
    logic        o_en3, o_en5;
    logic [29:0] o_bits3;
    logic [49:0] o_bits5;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t hist [$];
    obs_t expq [$];
    int   mcnt [5];
    logic [49:0] mlast;

    hdmi_tmds_encode_multi #(.NCH(3)) dut3 (
        .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_gb_di(i_gb_di),
        .i_vd(i_vd[23:0]), .i_cd(i_cd[5:0]), .i_aux(i_aux[11:0]),
        .o_en(o_en3), .o_tmds_bits(o_bits3));

    hdmi_tmds_encode_multi #(.NCH(5)) dut5 (
        .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_gb_di(i_gb_di),
        .i_vd(i_vd), .i_cd(i_cd), .i_aux(i_aux),
        .o_en(o_en5), .o_tmds_bits(o_bits5));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t mk_obs(input logic en, input logic [49:0] b);
        return {en, b[29:0], en, b};
    endfunction

    // Called at a negedge: drive one beat, record the outputs at the next negedge.
    task automatic tick(input logic en, input logic [1:0] mode, input logic gb,
                        input logic [39:0] vd, input logic [9:0] cd, input logic [19:0] aux);
        i_en = en; i_mode = mode; i_gb_di = gb; i_vd = vd; i_cd = cd; i_aux = aux;
        @(negedge clk);
        hist.push_back({o_en3, o_bits3, o_en5, o_bits5});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, M_CTL, 1'b0, '0, '0, '0);
    endtask

    // Called at a negedge: asynchronous reset pulse raised between clock edges.
    task automatic apply_reset;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_en3, o_bits3, o_en5, o_bits5} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h exp 0", {o_en3, o_bits3, o_en5, o_bits5});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        apply_reset;
        tick(1'b1, M_CTL, 1'b0, '0, 10'b1100110011, '0);
        tick(1'b1, M_VID, 1'b0, 40'hFF_FF_FF_FF_FF, '0, '0);
        apply_reset;
        hist.delete();
        idle(6);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (hist[i] !== mk_obs(1'b0, '0)) begin
                n_err++;
                $display("FAIL reset_flush[%0d]: got %h exp %h", i, hist[i], mk_obs(1'b0, '0));
            end
        end
    endtask

    task automatic test_ctl;
        logic [49:0] b;
        apply_reset;
        hist.delete();
        tick(1'b1, M_CTL, 1'b0, '0, {2'b00, 2'b10, 2'b01, 2'b11, 2'b00}, '0);
        idle(5);
        b = {10'b1101010100, 10'b0101010100, 10'b0010101011, 10'b1010101011, 10'b1101010100};
        n_vec++;
        if (hist[2] !== mk_obs(1'b0, '0)) begin
            n_err++; $display("FAIL ctl_early: got %h exp %h", hist[2], mk_obs(1'b0, '0));
        end
        n_vec++;
        if (hist[3] !== mk_obs(1'b1, b)) begin
            n_err++; $display("FAIL ctl_beat: got %h exp %h", hist[3], mk_obs(1'b1, b));
        end
        n_vec++;
        if (hist[4] !== mk_obs(1'b0, b)) begin
            n_err++; $display("FAIL ctl_hold: got %h exp %h", hist[4], mk_obs(1'b0, b));
        end
    endtask

    // Lanes 0/2/4 send 0x00, lanes 1/3 send 0xFF, three beats back to back from cnt=0.
    task automatic test_video;
        obs_t e [3];
        apply_reset;
        hist.delete();
        for (int i = 0; i < 3; i++) tick(1'b1, M_VID, 1'b0, 40'h00_FF_00_FF_00, '0, '0);
        idle(4);
        e[0] = mk_obs(1'b1, {Z1, F1, Z1, F1, Z1});
        e[1] = mk_obs(1'b1, {Z2, F2, Z2, F2, Z2});
        e[2] = mk_obs(1'b1, {Z1, F2, Z1, F2, Z1});
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hist[3+i] !== e[i]) begin
                n_err++; $display("FAIL video_b2b[%0d]: got %h exp %h", i, hist[3+i], e[i]);
            end
        end
    endtask

    task automatic test_bubble;
        obs_t e [3];
        apply_reset;
        hist.delete();
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        idle(1);
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        idle(4);
        e[0] = mk_obs(1'b1, {5{Z1}});
        e[1] = mk_obs(1'b0, {5{Z1}});
        e[2] = mk_obs(1'b1, {5{Z2}});
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hist[3+i] !== e[i]) begin
                n_err++; $display("FAIL video_bubble[%0d]: got %h exp %h", i, hist[3+i], e[i]);
            end
        end
    endtask

    task automatic test_ctl_resets_cnt;
        obs_t e [4];
        apply_reset;
        hist.delete();
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        tick(1'b1, M_CTL, 1'b0, '0, '0, '0);
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        idle(4);
        e[0] = mk_obs(1'b1, {5{Z1}});
        e[1] = mk_obs(1'b1, {5{Z2}});
        e[2] = mk_obs(1'b1, {5{10'b1101010100}});
        e[3] = mk_obs(1'b1, {5{Z1}});
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (hist[3+i] !== e[i]) begin
                n_err++; $display("FAIL ctl_cnt_clear[%0d]: got %h exp %h", i, hist[3+i], e[i]);
            end
        end
    endtask

    task automatic test_terc4;
        logic [3:0] nib;
        obs_t       e;
        apply_reset;
        hist.delete();
        for (int n = 0; n < 16; n++) begin
            nib = 4'(n);
            tick(1'b1, M_TERC, 1'b0, '0, '0, {5{nib}});
        end
        idle(4);
        for (int n = 0; n < 16; n++) begin
            e = mk_obs(1'b1, {5{TERC4_TAB[n]}});
            n_vec++;
            if (hist[3+n] !== e) begin
                n_err++; $display("FAIL terc4[%0d]: got %h exp %h", n, hist[3+n], e);
            end
        end
    endtask

    // Video beat leaves cnt=-8; the guard bands must clear it so the last 0x00 encodes as after reset.
    task automatic test_guard;
        obs_t e [4];
        apply_reset;
        hist.delete();
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        tick(1'b1, M_GB, 1'b0, '0, '0, 20'h5A5A5);
        tick(1'b1, M_GB, 1'b1, '0, '0, 20'h0539C);
        tick(1'b1, M_VID, 1'b0, '0, '0, '0);
        idle(4);
        e[0] = mk_obs(1'b1, {5{Z1}});
        e[1] = mk_obs(1'b1, {GB_B, GB_A, GB_A, GB_B, GB_A});
        e[2] = mk_obs(1'b1, {GB_B, 10'b0100011110, GB_B, GB_B, 10'b1010001110});
        e[3] = mk_obs(1'b1, {5{Z1}});
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (hist[3+i] !== e[i]) begin
                n_err++; $display("FAIL guard[%0d]: got %h exp %h", i, hist[3+i], e[i]);
            end
        end
    endtask

    // Reference TMDS video encoder, written straight from the DVI algorithm with integer counts.
    task automatic model_video(input logic [7:0] d, input int c_in,
                               output logic [9:0] code, output int c_out);
        int         n1d, n1q, q8;
        logic [8:0] q;
        n1d  = $countones(d);
        q[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ~^ d[i];
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        q8  = q[8] ? 1 : 0;
        n1q = $countones(q[7:0]);
        if (c_in == 0 || n1q == 4) begin
            code  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            c_out = q8 == 1 ? c_in + n1q - (8 - n1q) : c_in + (8 - n1q) - n1q;
        end else if ((c_in > 0 && n1q > 4) || (c_in < 0 && n1q < 4)) begin
            code  = {1'b1, q[8], ~q[7:0]};
            c_out = c_in + 2 * q8 + (8 - n1q) - n1q;
        end else begin
            code  = {1'b0, q[8], q[7:0]};
            c_out = c_in - 2 * (1 - q8) + n1q - (8 - n1q);
        end
    endtask

    task automatic model_reset;
        for (int l = 0; l < 5; l++) mcnt[l] = 0;
        mlast = '0;
        for (int i = 0; i < 3; i++) expq.push_back(mk_obs(1'b0, '0));
    endtask

    task automatic rnd_beat(input logic force_idle);
        logic        en, gb;
        logic [1:0]  mode;
        logic [63:0] r64;
        logic [39:0] vd;
        logic [9:0]  cd, code;
        logic [19:0] aux;
        int          sel, c;
        en  = force_idle ? 1'b0 : ($urandom_range(0, 4) != 0);
        sel = $urandom_range(0, 9);
        mode = sel < 6 ? M_VID : sel == 6 ? M_CTL : sel == 7 ? M_TERC : M_GB;
        gb  = 1'($urandom_range(0, 1));
        r64 = {$urandom(), $urandom()};
        vd  = r64[39:0];
        cd  = 10'($urandom());
        aux = 20'($urandom());
        if (en) begin
            for (int l = 0; l < 5; l++) begin
                code = '0;
                case (mode)
                    M_CTL:  begin code = CTL_TAB[cd[2*l +: 2]]; mcnt[l] = 0; end
                    M_VID:  begin model_video(vd[8*l +: 8], mcnt[l], code, c); mcnt[l] = c; end
                    M_TERC: begin code = TERC4_TAB[aux[4*l +: 4]]; mcnt[l] = 0; end
                    default: begin
                        if (!gb) code = (l % 3 == 1) ? GB_B : GB_A;
                        else     code = (l % 3 == 0) ? TERC4_TAB[aux[4*l +: 4]] : GB_B;
                        mcnt[l] = 0;
                    end
                endcase
                mlast[10*l +: 10] = code;
            end
        end
        expq.push_back(mk_obs(en, mlast));
        tick(en, mode, gb, vd, cd, aux);
    endtask

    task automatic test_random;
        apply_reset;
        hist.delete();
        expq.delete();
        model_reset;
        for (int t = 0; t < 150; t++) rnd_beat(1'b0);
        apply_reset;
        while (expq.size() > hist.size()) void'(expq.pop_back());
        model_reset;
        for (int t = 0; t < 150; t++) rnd_beat(1'b0);
        for (int t = 0; t < 4; t++) rnd_beat(1'b1);
        for (int i = 0; i < hist.size(); i++) begin
            n_vec++;
            if (hist[i] !== expq[i]) begin
                n_err++; $display("FAIL random[%0d]: got %h exp %h", i, hist[i], expq[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ctl;
        test_video;
        test_bubble;
        test_ctl_resets_cnt;
        test_terc4;
        test_guard;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
